spi_tx_fifo_n: RTL and testbench

Parametrised SPI master transmitter, successor to the fixed 16-bit serializer on the OFDM output path. It accepts words over a valid/ready handshake into a small FIFO and serializes each word MSB- or LSB-first. It generates its own divided SPI clock with selectable CPOL/CPHA and enforces a programmable chip-select gap between words. It sits between the OFDM sample formatter and the external DAC/link.

---
 rtl/spi_tx_fifo_n.sv | 187 ++++++++++++++++++
 tb/tb_spi_tx_fifo_n.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_fifo_n.sv
// SPI master transmitter with an input FIFO.
// Words arrive over valid/ready and are held in a small circular buffer.
// Each word is shifted out on mosi, MSB- or LSB-first, under a divided spi_clk
// with selectable CPOL/CPHA. cs_n is released for a programmable gap between words.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | cs_n high, spi_clk at CPOL, waiting for a non-empty FIFO
// S_LOAD  | pop FIFO head into the shift register, drop cs_n, drive first bit
// S_SHIFT | 2*CLK_DIV cycles per bit; half A then half B
// S_HOLD  | CLK_DIV cycles of hold with spi_clk idle and cs_n still low
// S_GAP   | CS_GAP cycles with cs_n high before the next word
module spi_tx_fifo_n #(
    parameter int DATA_W     = 16,
    parameter int CLK_DIV    = 2,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int FIFO_DEPTH = 4,
    parameter int CS_GAP     = 2
) (
    input  logic                        sclk,
    input  logic                        reset_n,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        valid,
    output logic                        ready,
    output logic                        spi_clk,
    output logic                        mosi,
    output logic                        cs_n,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int PH_W    = $clog2(2 * CLK_DIV);
    localparam int BIT_W   = $clog2(DATA_W) + 1;
    localparam int TMR_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_B_PRE = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(CS_GAP - 1);
    // spi_clk level during half A of a bit; half B is its inverse
    localparam logic LVL_A = CPOL ^ CPHA;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_HOLD, S_GAP} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [DATA_W-1:0]   shift_reg;
    logic [DATA_W-1:0]   shift_nxt;
    logic [DATA_W-1:0]   head;
    logic                head_first;
    logic                mosi_nxt;
    logic [PH_W-1:0]     phase;
    logic [BIT_W-1:0]    bit_cnt;
    logic [TMR_W-1:0]    tmr;
    logic                push;
    logic                pop;

    assign ready = (fifo_count < CNT_FULL);
    assign push  = valid && ready;
    assign pop   = (state == S_LOAD);
    assign busy  = (state != S_IDLE);
    assign head  = mem[rd_ptr];

    // Bit-order dependent selection of the first bit and the next shifted word
    always_comb begin
        head_first = head[0];
        shift_nxt  = {1'b0, shift_reg[DATA_W-1:1]};
        mosi_nxt   = shift_reg[1];
        if (MSB_FIRST) begin
            head_first = head[DATA_W-1];
            shift_nxt  = {shift_reg[DATA_W-2:0], 1'b0};
            mosi_nxt   = shift_reg[DATA_W-2];
        end
    end

    // FIFO storage; contents need no reset since the pointers gate visibility
    always_ff @(posedge sclk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Frame sequencer with registered spi_clk, mosi, cs_n and done
    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cs_n      <= 1'b1;
            spi_clk   <= CPOL;
            mosi      <= 1'b0;
            done      <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            phase     <= '0;
            tmr       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    cs_n    <= 1'b1;
                    spi_clk <= CPOL;
                    if (fifo_count != '0) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    shift_reg <= head;
                    mosi      <= head_first;
                    cs_n      <= 1'b0;
                    bit_cnt   <= '0;
                    phase     <= '0;
                    spi_clk   <= LVL_A;
                    state     <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (phase == PH_LAST) begin
                        phase <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            spi_clk <= CPOL;
                            tmr     <= HOLD_LD;
                            state   <= S_HOLD;
                        end else begin
                            bit_cnt   <= bit_cnt + BIT_W'(1);
                            shift_reg <= shift_nxt;
                            mosi      <= mosi_nxt;
                            spi_clk   <= LVL_A;
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                        if (phase == PH_B_PRE) begin
                            spi_clk <= ~LVL_A;
                        end
                    end
                end
                S_HOLD: begin
                    if (tmr == '0) begin
                        cs_n  <= 1'b1;
                        done  <= 1'b1;
                        tmr   <= GAP_LD;
                        state <= S_GAP;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                S_GAP: begin
                    if (tmr == '0) begin
                        state <= (fifo_count != '0) ? S_LOAD : S_IDLE;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_tx_fifo_n.sv
// Bench for spi_tx_fifo_n: one instance at default parameters and one with
// CPOL=1, CPHA=1, LSB-first, 8-bit words, CLK_DIV=1, CS_GAP=1.
// A bus monitor per instance rebuilds each word from mosi at the sampling
// edges of spi_clk and compares it, with frame timing, against a queue of
// accepted words.
module tb_spi_tx_fifo_n;

    localparam int DW_A  = 16;
    localparam int CD_A  = 2;
    localparam bit CPOL_A = 1'b0;
    localparam bit CPHA_A = 1'b0;
    localparam bit MSB_A  = 1'b1;
    localparam int LOW_A = 66;   // 2*2*16 + 2
    localparam int PER_A = 69;   // 1 + 64 + 2 + 2

    localparam int DW_B  = 8;
    localparam int CD_B  = 1;
    localparam bit CPOL_B = 1'b1;
    localparam bit CPHA_B = 1'b1;
    localparam bit MSB_B  = 1'b0;
    localparam int LOW_B = 17;   // 2*1*8 + 1
    localparam int PER_B = 19;   // 1 + 16 + 1 + 1

    localparam int DEP = 4;
    // data is sampled when spi_clk moves to this level (leading edge for CPHA=0)
    localparam bit SMP_A = CPHA_A ? CPOL_A : ~CPOL_A;
    localparam bit SMP_B = CPHA_B ? CPOL_B : ~CPOL_B;

    logic        sclk = 1'b0;
    logic        reset_n;
    logic [15:0] data_a = '0;
    logic        valid_a = 1'b0;
    logic        ready_a, spi_clk_a, mosi_a, cs_n_a, busy_a, done_a;
    logic [2:0]  fifo_count_a;
    logic [7:0]  data_b = '0;
    logic        valid_b = 1'b0;
    logic        ready_b, spi_clk_b, mosi_b, cs_n_b, busy_b, done_b;
    logic [2:0]  fifo_count_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_a = 0;
    int acc_b = 0;

    typedef struct {
        logic [15:0] d;
        int          acc;
    } item_t;
    item_t qa[$];
    item_t qb[$];

    spi_tx_fifo_n #(
        .DATA_W(DW_A), .CLK_DIV(CD_A), .CPOL(CPOL_A), .CPHA(CPHA_A),
        .MSB_FIRST(MSB_A), .FIFO_DEPTH(DEP), .CS_GAP(2)
    ) dut_a (
        .sclk(sclk), .reset_n(reset_n), .data_in(data_a), .valid(valid_a),
        .ready(ready_a), .spi_clk(spi_clk_a), .mosi(mosi_a), .cs_n(cs_n_a),
        .busy(busy_a), .done(done_a), .fifo_count(fifo_count_a)
    );

    spi_tx_fifo_n #(
        .DATA_W(DW_B), .CLK_DIV(CD_B), .CPOL(CPOL_B), .CPHA(CPHA_B),
        .MSB_FIRST(MSB_B), .FIFO_DEPTH(DEP), .CS_GAP(1)
    ) dut_b (
        .sclk(sclk), .reset_n(reset_n), .data_in(data_b), .valid(valid_b),
        .ready(ready_b), .spi_clk(spi_clk_b), .mosi(mosi_b), .cs_n(cs_n_b),
        .busy(busy_b), .done(done_b), .fifo_count(fifo_count_b)
    );

    always #5 sclk = ~sclk;

    // cycle index of the most recent rising edge, and handshake acceptance counts
    always @(posedge sclk) begin
        cyc <= cyc + 1;
        if (!reset_n) begin
            acc_a <= 0;
            acc_b <= 0;
        end else begin
            if (valid_a && ready_a) acc_a <= acc_a + 1;
            if (valid_b && ready_b) acc_b <= acc_b + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // ---------------- monitor, instance A ----------------
    int          nb_a = 0, tr_a = 0, falls_a = 0, frames_a = 0, last_fall_a = -1000;
    logic        pcs_a = 1'b1, pspi_a = CPOL_A, rise_a;
    logic [15:0] word_a = '0;

    initial forever begin
        @(negedge sclk);
        if (!reset_n) begin
            pcs_a = 1'b1; pspi_a = CPOL_A; nb_a = 0; tr_a = 0;
            falls_a = 0; last_fall_a = -1000;
        end else begin
            if (pcs_a && !cs_n_a) begin
                falls_a++;
                chk("a_frame_expected", 32'(qa.size() != 0), 1);
                if (qa.size() != 0)
                    chk("a_start_cycle", cyc, imax(last_fall_a + PER_A, qa[0].acc + 2));
                chk("a_busy_in_frame", 32'(busy_a), 1);
                last_fall_a = cyc; nb_a = 0; tr_a = 0; word_a = '0;
            end
            if (!cs_n_a && spi_clk_a !== pspi_a) begin
                if (tr_a == 0) chk("a_first_sck_delay", cyc - last_fall_a, CPHA_A ? 0 : CD_A);
                tr_a++;
                if (spi_clk_a === SMP_A) begin
                    if (MSB_A) word_a = {word_a[14:0], mosi_a};
                    else if (nb_a < DW_A) word_a[nb_a] = mosi_a;
                    nb_a++;
                end
            end
            rise_a = !pcs_a && cs_n_a;
            if (done_a || rise_a) chk("a_done_at_cs_rise", 32'(done_a), 32'(rise_a));
            if (rise_a) begin
                chk("a_cs_low_cycles", cyc - last_fall_a, LOW_A);
                chk("a_bits", nb_a, DW_A);
                chk("a_sck_edges", tr_a, 2 * DW_A);
                chk("a_sck_idle", 32'(spi_clk_a), 32'(CPOL_A));
                chk("a_word_present", 32'(qa.size() != 0), 1);
                if (qa.size() != 0) begin
                    chk("a_word", 32'(word_a), 32'(qa[0].d));
                    void'(qa.pop_front());
                end
                frames_a++;
            end
            chk("a_fifo_count", 32'(fifo_count_a), acc_a - falls_a);
            chk("a_ready", 32'(ready_a), 32'((acc_a - falls_a) < DEP));
            pcs_a = cs_n_a; pspi_a = spi_clk_a;
        end
    end

    // ---------------- monitor, instance B ----------------
    int          nb_b = 0, tr_b = 0, falls_b = 0, frames_b = 0, last_fall_b = -1000;
    logic        pcs_b = 1'b1, pspi_b = CPOL_B, rise_b;
    logic [7:0]  word_b = '0;

    initial forever begin
        @(negedge sclk);
        if (!reset_n) begin
            pcs_b = 1'b1; pspi_b = CPOL_B; nb_b = 0; tr_b = 0;
            falls_b = 0; last_fall_b = -1000;
        end else begin
            if (pcs_b && !cs_n_b) begin
                falls_b++;
                chk("b_frame_expected", 32'(qb.size() != 0), 1);
                if (qb.size() != 0)
                    chk("b_start_cycle", cyc, imax(last_fall_b + PER_B, qb[0].acc + 2));
                chk("b_busy_in_frame", 32'(busy_b), 1);
                last_fall_b = cyc; nb_b = 0; tr_b = 0; word_b = '0;
            end
            if (!cs_n_b && spi_clk_b !== pspi_b) begin
                if (tr_b == 0) chk("b_first_sck_delay", cyc - last_fall_b, CPHA_B ? 0 : CD_B);
                tr_b++;
                if (spi_clk_b === SMP_B) begin
                    if (MSB_B) word_b = {word_b[6:0], mosi_b};
                    else if (nb_b < DW_B) word_b[nb_b] = mosi_b;
                    nb_b++;
                end
            end
            rise_b = !pcs_b && cs_n_b;
            if (done_b || rise_b) chk("b_done_at_cs_rise", 32'(done_b), 32'(rise_b));
            if (rise_b) begin
                chk("b_cs_low_cycles", cyc - last_fall_b, LOW_B);
                chk("b_bits", nb_b, DW_B);
                chk("b_sck_edges", tr_b, 2 * DW_B);
                chk("b_sck_idle", 32'(spi_clk_b), 32'(CPOL_B));
                chk("b_word_present", 32'(qb.size() != 0), 1);
                if (qb.size() != 0) begin
                    chk("b_word", 32'(word_b), 32'(qb[0].d));
                    void'(qb.pop_front());
                end
                frames_b++;
            end
            chk("b_fifo_count", 32'(fifo_count_b), acc_b - falls_b);
            chk("b_ready", 32'(ready_b), 32'((acc_b - falls_b) < DEP));
            pcs_b = cs_n_b; pspi_b = spi_clk_b;
        end
    end

    // ---------------- drivers ----------------
    task automatic push_a(input logic [15:0] d);
        int k = 0;
        data_a  = d;
        valid_a = 1'b1;
        while (!ready_a && k < 500) begin
            @(negedge sclk);
            k++;
        end
        chk("a_push_accepted", 32'(ready_a), 1);
        qa.push_back('{d, cyc + 1});
        @(negedge sclk);
        valid_a = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] d);
        int k = 0;
        data_b  = d;
        valid_b = 1'b1;
        while (!ready_b && k < 500) begin
            @(negedge sclk);
            k++;
        end
        chk("b_push_accepted", 32'(ready_b), 1);
        qb.push_back('{16'(d), cyc + 1});
        @(negedge sclk);
        valid_b = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (k < 4000 && !(qa.size() == 0 && qb.size() == 0 && !busy_a && !busy_b
                             && fifo_count_a == 0 && fifo_count_b == 0)) begin
            @(negedge sclk);
            k++;
        end
        chk("drain_all_words", 32'(qa.size() + qb.size()), 0);
        chk("idle_busy_a", 32'(busy_a), 0);
        chk("idle_busy_b", 32'(busy_b), 0);
        chk("idle_cs_a", 32'(cs_n_a), 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int k;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_cs_a", 32'(cs_n_a), 1);
        chk("rst_sck_a", 32'(spi_clk_a), 0);
        chk("rst_mosi_a", 32'(mosi_a), 0);
        chk("rst_busy_a", 32'(busy_a), 0);
        chk("rst_done_a", 32'(done_a), 0);
        chk("rst_count_a", 32'(fifo_count_a), 0);
        chk("rst_ready_a", 32'(ready_a), 1);
        chk("rst_cs_b", 32'(cs_n_b), 1);
        chk("rst_sck_b", 32'(spi_clk_b), 1);
        chk("rst_ready_b", 32'(ready_b), 1);
        repeat (2) @(negedge sclk);
        #2 reset_n = 1'b1;
        @(negedge sclk);

        // single reference words on both instances
        push_a(16'hA5C3);
        push_b(8'h81);
        wait_idle();
        chk("a_frames_after_first", frames_a, 1);
        chk("b_frames_after_first", frames_b, 1);

        // random words with random idle spacing
        for (int i = 0; i < 6; i++) begin
            push_a(16'($urandom));
            push_b(8'($urandom));
            repeat ($urandom_range(0, 80)) @(negedge sclk);
        end
        wait_idle();

        // fill the FIFO behind a frame in flight; the fifth word must wait
        push_a(16'($urandom));
        k = 0;
        while (cs_n_a && k < 200) begin
            @(negedge sclk);
            k++;
        end
        for (int i = 0; i < 4; i++) push_a(16'($urandom));
        chk("a_full_count", 32'(fifo_count_a), 4);
        chk("a_full_ready", 32'(ready_a), 0);
        push_a(16'($urandom));
        wait_idle();

        // from idle: third push coincides with the first pop at count 2
        push_a(16'h1234);
        push_a(16'h5678);
        push_a(16'h9ABC);
        chk("a_push_pop_count", 32'(fifo_count_a), 2);
        for (int i = 0; i < 6; i++) push_a(16'($urandom));
        for (int i = 0; i < 9; i++) push_b(8'($urandom));
        wait_idle();

        // reset in the middle of a frame with another word queued
        push_a(16'hF00F);
        push_a(16'h0FF0);
        k = 0;
        while (nb_a != 7 && k < 500) begin
            @(negedge sclk);
            k++;
        end
        chk("a_reached_bit7", nb_a, 7);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_cs_a", 32'(cs_n_a), 1);
        chk("mid_rst_sck_a", 32'(spi_clk_a), 0);
        chk("mid_rst_count_a", 32'(fifo_count_a), 0);
        chk("mid_rst_done_a", 32'(done_a), 0);
        chk("mid_rst_busy_a", 32'(busy_a), 0);
        chk("mid_rst_ready_a", 32'(ready_a), 1);
        qa.delete();
        qb.delete();
        @(negedge sclk);
        @(negedge sclk);
        #2 reset_n = 1'b1;
        @(negedge sclk);
        push_a(16'h3C5A);
        push_b(8'h5A);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
